drrip_dueling_ctrl: RTL and testbench



---
 rtl/drrip_pkg.sv | 29 ++
 rtl/drrip_dueling_ctrl_if.sv | 32 +++
 rtl/rrip_victim_finder.sv | 30 +++
 rtl/drrip_dueling_ctrl.sv | 153 +++++++++++++++
 tb/tb_drrip_dueling_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/drrip_pkg.sv
// rtl/drrip_pkg.sv - shared types and RRPV constant helpers for the DRRIP controller
// Contents:
//   rrip_policy_e  insertion policy (SRRIP=0, BRRIP=1)
//   fsm_state_e    controller states IDLE/SEARCH/AGE/RESP
//   rrpv_distant   DISTANT value (2**m-1) for an m-bit RRPV
//   rrpv_long      LONG value (2**m-2) for an m-bit RRPV
package drrip_pkg;

    typedef enum logic {
        SRRIP = 1'b0,
        BRRIP = 1'b1
    } rrip_policy_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_AGE    = 2'd2,
        ST_RESP   = 2'd3
    } fsm_state_e;

    function automatic int rrpv_distant(input int m);
        return (1 << m) - 1;
    endfunction

    function automatic int rrpv_long(input int m);
        return (1 << m) - 2;
    endfunction

endpackage

// File: rtl/drrip_dueling_ctrl_if.sv
// rtl/drrip_dueling_ctrl_if.sv - request/response bundle between cache and DRRIP controller
// Signals:
//   req_valid/req_ready/req_index/req_hit/req_hit_way   lookup request
//   resp_valid/resp_ready/resp_hit/resp_way/resp_policy  lookup response
//   psel_msb                                            current follower policy
// Modports: master = cache side, slave = controller side.
interface drrip_dueling_ctrl_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int SET_SIZE    = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [INDEX_WIDTH-1:0] req_index;
    logic                   req_hit;
    logic [SET_SIZE-1:0]    req_hit_way;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_hit;
    logic [SET_SIZE-1:0]    resp_way;
    logic                   resp_policy;
    logic                   psel_msb;

    modport master (
        output req_valid, req_index, req_hit, req_hit_way, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_policy, psel_msb
    );

    modport slave (
        input  req_valid, req_index, req_hit, req_hit_way, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_way, resp_policy, psel_msb
    );
endinterface

// File: rtl/rrip_victim_finder.sv
// rtl/rrip_victim_finder.sv - combinational search for the lowest way at DISTANT
// Ports:
//   rrpv   in   RRPVs of one set, way 0 in the low bits
//   found  out  some way holds DISTANT
//   way    out  lowest way holding DISTANT (0 when none)
module rrip_victim_finder
    import drrip_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4,
    parameter int SET_SIZE      = 2,
    parameter int M             = 2
) (
    input  logic [ASSOCIATIVITY-1:0][M-1:0] rrpv,
    output logic                            found,
    output logic [SET_SIZE-1:0]             way
);
    localparam logic [M-1:0] DISTANT = M'(rrpv_distant(M));

    // Scan from the top way down so the last match written is the lowest one.
    always_comb begin
        found = 1'b0;
        way   = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (rrpv[w] == DISTANT) begin
                found = 1'b1;
                way   = SET_SIZE'(w);
            end
        end
    end
endmodule

// File: rtl/drrip_dueling_ctrl.sv
// rtl/drrip_dueling_ctrl.sv - DRRIP replacement controller with set dueling and RRPV table
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   bus    slave side of drrip_dueling_ctrl_if (request, response, psel_msb)
// Build option: DRRIP_FP_PROMOTE_EN makes a hit decrement the way's RRPV (saturating
// at 0) instead of setting it to IMMEDIATE.
module drrip_dueling_ctrl
    import drrip_pkg::*;
#(
    parameter int ASSOCIATIVITY     = 4,
    parameter int SET_SIZE          = 2,
    parameter int INDEX_WIDTH       = 6,
    parameter int DEPTH             = 64,
    parameter int M                 = 2,
    parameter int PSEL_WIDTH        = 10,
    parameter int LEADER_STRIDE     = 16,
    parameter int BRRIP_COUNTER_LEN = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    drrip_dueling_ctrl_if.slave   bus
);
    localparam logic [M-1:0]          DISTANT    = M'(rrpv_distant(M));
    localparam logic [M-1:0]          LONG       = M'(rrpv_long(M));
    localparam logic [M-1:0]          IMMEDIATE  = '0;
    localparam logic [PSEL_WIDTH-1:0] PSEL_INIT  = PSEL_WIDTH'(1) << (PSEL_WIDTH - 1);
    localparam logic [PSEL_WIDTH-1:0] PSEL_MAX   = '1;
    localparam int                    STRIDE_LOG = $clog2(LEADER_STRIDE);

    fsm_state_e                       state_q, state_d;
    logic [ASSOCIATIVITY-1:0][M-1:0]  rrpv_q [DEPTH];
    logic [INDEX_WIDTH-1:0]           idx_q;
    logic [PSEL_WIDTH-1:0]            psel_q;
    logic [BRRIP_COUNTER_LEN-1:0]     brrip_cnt_q;
    logic                             resp_hit_q;
    logic [SET_SIZE-1:0]              resp_way_q;
    logic                             resp_policy_q;

    logic                             victim_found;
    logic [SET_SIZE-1:0]              victim_way;
    logic                             leader_srrip;
    logic                             leader_brrip;
    rrip_policy_e                     miss_policy;
    logic [M-1:0]                     ins_val;
    logic [M-1:0]                     hit_val;

    rrip_victim_finder #(
        .ASSOCIATIVITY (ASSOCIATIVITY),
        .SET_SIZE      (SET_SIZE),
        .M             (M)
    ) u_finder (
        .rrpv  (rrpv_q[idx_q]),
        .found (victim_found),
        .way   (victim_way)
    );

    // Leader classification only looks at the low index bits (stride is a power of two).
    assign leader_srrip = (idx_q[STRIDE_LOG-1:0] == STRIDE_LOG'(0));
    assign leader_brrip = (idx_q[STRIDE_LOG-1:0] == STRIDE_LOG'(1));
    assign miss_policy  = leader_srrip ? SRRIP :
                          leader_brrip ? BRRIP :
                          rrip_policy_e'(psel_q[PSEL_WIDTH-1]);
    // BRRIP inserts LONG only once per wrap of its throttle counter.
    assign ins_val = (miss_policy == SRRIP || brrip_cnt_q == '0) ? LONG : DISTANT;

`ifdef DRRIP_FP_PROMOTE_EN
    logic [M-1:0] hit_cur;
    assign hit_cur = rrpv_q[bus.req_index][bus.req_hit_way];
    assign hit_val = (hit_cur == IMMEDIATE) ? IMMEDIATE : hit_cur - 1'b1;
`else
    assign hit_val = IMMEDIATE;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = bus.req_hit ? ST_RESP : ST_SEARCH;
            ST_SEARCH: state_d = victim_found ? ST_RESP : ST_AGE;
            ST_AGE:    state_d = ST_SEARCH;
            ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    rrpv_q[s][w] <= DISTANT;
                end
            end
            idx_q         <= '0;
            psel_q        <= PSEL_INIT;
            brrip_cnt_q   <= '0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_policy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        idx_q <= bus.req_index;
                        if (bus.req_hit) begin
                            rrpv_q[bus.req_index][bus.req_hit_way] <= hit_val;
                            resp_hit_q    <= 1'b1;
                            resp_way_q    <= bus.req_hit_way;
                            resp_policy_q <= 1'b0;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (victim_found) begin
                        rrpv_q[idx_q][victim_way] <= ins_val;
                        resp_hit_q    <= 1'b0;
                        resp_way_q    <= victim_way;
                        resp_policy_q <= miss_policy;
                        if (leader_srrip && psel_q != PSEL_MAX) begin
                            psel_q <= psel_q + 1'b1;
                        end else if (leader_brrip && psel_q != '0) begin
                            psel_q <= psel_q - 1'b1;
                        end
                        if (miss_policy == BRRIP) begin
                            brrip_cnt_q <= brrip_cnt_q + 1'b1;
                        end
                    end
                end
                ST_AGE: begin
                    // No way is DISTANT here, so the increment cannot wrap.
                    for (int w = 0; w < ASSOCIATIVITY; w++) begin
                        rrpv_q[idx_q][w] <= rrpv_q[idx_q][w] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_way    = resp_way_q;
    assign bus.resp_policy = resp_policy_q;
    assign bus.psel_msb    = psel_q[PSEL_WIDTH-1];
endmodule

// File: tb/tb_drrip_dueling_ctrl.sv
// tb/tb_drrip_dueling_ctrl.sv - directed table-driven bench for drrip_dueling_ctrl
// Covers reset state, hits, leader/follower misses with aging, PSEL saturation,
// response back-pressure and reset while aging. Honours DRRIP_FP_PROMOTE_EN.
module tb_drrip_dueling_ctrl;

    typedef struct {
        logic [5:0] idx;
        logic       hit;
        logic [1:0] way;
        logic [1:0] e_way;
        logic       e_pol;
        int         e_lat;
        int         e_psel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    drrip_dueling_ctrl_if #(.INDEX_WIDTH(6), .SET_SIZE(2)) bus ();

    drrip_dueling_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one request, return cycles from acceptance edge until resp_valid is seen.
    task automatic issue(input logic [5:0] idx, input logic hit, input logic [1:0] way,
                         output int lat);
        int w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        bus.req_valid   = 1'b1;
        bus.req_index   = idx;
        bus.req_hit     = hit;
        bus.req_hit_way = way;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    vec_t vecs[$];
    int   lat;
    int   bad;
    logic [1:0] s_way;
    logic       s_hit, s_pol;
    logic [1:0] exp_hit53;

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_index   = '0;
        bus.req_hit     = 1'b0;
        bus.req_hit_way = '0;
        bus.resp_ready  = 1'b0;

        // idx, hit, way, exp_way, exp_policy, exp_latency, exp_psel_after
        vecs.push_back('{6'd2, 1'b0, 2'd0, 2'd0, 1'b1, 2, 512});
        vecs.push_back('{6'd5, 1'b1, 2'd3, 2'd3, 1'b0, 1, 512});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2, 513});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd1, 1'b0, 2, 514});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd2, 1'b0, 2, 515});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd3, 1'b0, 2, 516});
        // Double hits drive a LONG way to 0 under either promotion scheme.
        vecs.push_back('{6'd0, 1'b1, 2'd1, 2'd1, 1'b0, 1, 516});
        vecs.push_back('{6'd0, 1'b1, 2'd1, 2'd1, 1'b0, 1, 516});
        vecs.push_back('{6'd0, 1'b1, 2'd2, 2'd2, 1'b0, 1, 516});
        vecs.push_back('{6'd0, 1'b1, 2'd2, 2'd2, 1'b0, 1, 516});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd0, 1'b0, 4, 517});
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd3, 1'b0, 2, 518});
        vecs.push_back('{6'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1, 518});
        vecs.push_back('{6'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1, 518});
        vecs.push_back('{6'd0, 1'b1, 2'd3, 2'd3, 1'b0, 1, 518});
        vecs.push_back('{6'd0, 1'b1, 2'd3, 2'd3, 1'b0, 1, 518});
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{6'd1, 1'b0, 2'd0, 2'd0, 1'b1, 2, 517 - i});
        end
        // Set 0 is now {0,1,1,0}: two aging passes, victim way 1.
        vecs.push_back('{6'd0, 1'b0, 2'd0, 2'd1, 1'b0, 6, 513});

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_hit", 32'(bus.resp_hit), 0);
        chk("rst_resp_way", 32'(bus.resp_way), 0);
        chk("rst_resp_policy", 32'(bus.resp_policy), 0);
        chk("rst_psel_msb", 32'(bus.psel_msb), 1);
        chk("rst_psel", 32'(dut.psel_q), 512);

        foreach (vecs[i]) begin
            issue(vecs[i].idx, vecs[i].hit, vecs[i].way, lat);
            chk($sformatf("vec%0d_hit", i), 32'(bus.resp_hit), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_way", i), 32'(bus.resp_way), 32'(vecs[i].e_way));
            chk($sformatf("vec%0d_policy", i), 32'(bus.resp_policy), 32'(vecs[i].e_pol));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
            finish_resp();
            chk($sformatf("vec%0d_psel", i), 32'(dut.psel_q), 32'(vecs[i].e_psel));
        end

`ifdef DRRIP_FP_PROMOTE_EN
        exp_hit53 = 2'd2;
`else
        exp_hit53 = 2'd0;
`endif
        chk("hit_set5_way3_rrpv", 32'(dut.rrpv_q[5][3]), 32'(exp_hit53));
        chk("miss_set2_way0_rrpv", 32'(dut.rrpv_q[2][0]), 2);
        chk("set0_after_aging", 32'(dut.rrpv_q[0]), 32'h0000_00BA);

        // Drive PSEL down to its floor from set 1 and keep pushing past it.
        for (int i = 0; i < 520; i++) begin
            issue(6'd1, 1'b0, 2'd0, lat);
            chk("sat_policy", 32'(bus.resp_policy), 1);
            finish_resp();
        end
        chk("sat_psel", 32'(dut.psel_q), 0);
        chk("sat_psel_msb", 32'(bus.psel_msb), 0);
        issue(6'd2, 1'b0, 2'd0, lat);
        chk("follower_srrip_policy", 32'(bus.resp_policy), 0);
        chk("follower_srrip_way", 32'(bus.resp_way), 1);
        chk("follower_srrip_latency", 32'(lat), 2);
        finish_resp();

        // Back-pressure: response held, stray request ignored.
        issue(6'd3, 1'b0, 2'd0, lat);
        s_hit = bus.resp_hit;
        s_way = bus.resp_way;
        s_pol = bus.resp_policy;
        chk("stall_first_way", 32'(s_way), 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.req_valid   = 1'b1;
                bus.req_index   = 6'd7;
                bus.req_hit     = 1'b1;
                bus.req_hit_way = 2'd2;
            end
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            chk("stall_resp_valid", 32'(bus.resp_valid), 1);
            chk("stall_req_ready", 32'(bus.req_ready), 0);
            chk("stall_resp_hit", 32'(bus.resp_hit), 32'(s_hit));
            chk("stall_resp_way", 32'(bus.resp_way), 32'(s_way));
            chk("stall_resp_policy", 32'(bus.resp_policy), 32'(s_pol));
        end
        finish_resp();
        chk("stall_done_resp_valid", 32'(bus.resp_valid), 0);
        chk("stall_done_req_ready", 32'(bus.req_ready), 1);
        chk("stall_stray_untouched", 32'(dut.rrpv_q[7][2]), 3);

        // Reset while aging: set 0 has no DISTANT way after this.
        for (int i = 0; i < 3; i++) begin
            issue(6'd0, 1'b1, 2'd2, lat);
            finish_resp();
        end
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_index   = 6'd0;
        bus.req_hit     = 1'b0;
        bus.req_hit_way = 2'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("age_no_resp_yet", 32'(bus.resp_valid), 0);
        chk("age_not_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("age_rst_req_ready", 32'(bus.req_ready), 1);
        chk("age_rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("age_rst_psel", 32'(dut.psel_q), 512);
        chk("age_rst_psel_msb", 32'(bus.psel_msb), 1);
        bad = 0;
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 4; w++) begin
                if (dut.rrpv_q[s][w] !== 2'd3) bad++;
            end
        end
        chk("age_rst_rrpv_all_distant", 32'(bad), 0);
        rst_n = 1'b1;

        // BRRIP counter restarted at 0: first insert LONG, second DISTANT.
        issue(6'd2, 1'b0, 2'd0, lat);
        chk("post_rst_policy", 32'(bus.resp_policy), 1);
        chk("post_rst_way", 32'(bus.resp_way), 0);
        chk("post_rst_latency", 32'(lat), 2);
        finish_resp();
        chk("post_rst_rrpv_long", 32'(dut.rrpv_q[2][0]), 2);
        issue(6'd2, 1'b0, 2'd0, lat);
        chk("post_rst_second_way", 32'(bus.resp_way), 1);
        finish_resp();
        chk("post_rst_rrpv_distant", 32'(dut.rrpv_q[2][1]), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
